// File: rtl/tag_frame_builder.sv
// -----------------------------------------------------------------------------
// tag_frame_builder
//
// Frames payload packets for the tag-chip transmit controller. Each packet of
// up to MAX_WORDS 16-bit words is wrapped as {PREAMBLE, payload, CRC-16} and
// presented right-aligned on tx_bits with its length on tx_nbits. A staging
// buffer holds the next frame; it is swapped into the active buffer only when
// the active buffer is empty or the controller signals frame_done, so tx_bits
// never changes while a frame is being sent.
//
// Ports
//   clk           single clock
//   reset         synchronous, active-high
//   in_tdata      payload word
//   in_tvalid     payload word valid
//   in_tlast      last word of packet
//   in_tready     word accepted when in_tvalid & in_tready at a rising edge
//   frame_done    one-cycle pulse: active frame fully sent
//   tx_bits       active frame, first-sent bit at tx_nbits-1, CRC LSB at bit 0
//   tx_nbits      active frame length in bits
//   frame_valid   tx_bits holds a frame
//   err_overflow  sticky: a packet exceeded MAX_WORDS
//   frames_sent   count of frame_done pulses seen while frame_valid was high
// -----------------------------------------------------------------------------
module tag_frame_builder #(
   parameter int          TX_BITS_WIDTH = 128,
   parameter int          BIT_CNT_WIDTH = 7,
   parameter int          MAX_WORDS     = 6,
   parameter int          PRE_WIDTH     = 16,
   parameter logic [15:0] PREAMBLE      = 16'hAAAA
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              in_tdata,
   input  logic                     in_tvalid,
   input  logic                     in_tlast,
   output logic                     in_tready,
   input  logic                     frame_done,
   output logic [TX_BITS_WIDTH-1:0] tx_bits,
   output logic [BIT_CNT_WIDTH:0]   tx_nbits,
   output logic                     frame_valid,
   output logic                     err_overflow,
   output logic [15:0]              frames_sent
);

   localparam int          PAY_W = 16 * MAX_WORDS;
   localparam int          CNT_W = $clog2(MAX_WORDS + 1);
   localparam int          NB_W  = BIT_CNT_WIDTH + 1;
   localparam logic [15:0] POLY  = 16'h1021;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CRC  = 2'd1,
      S_FULL = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [PAY_W-1:0]         payload;     // words of the current packet, first word highest
   logic [15:0]              cur_word;    // word being shifted through the CRC, MSB first
   logic [15:0]              crc;
   logic [3:0]               bit_cnt;
   logic [CNT_W-1:0]         word_cnt;
   logic                     last_q;
   logic [TX_BITS_WIDTH-1:0] stage_bits;
   logic [NB_W-1:0]          stage_nbits;

   logic                     accept;
   logic                     crc_fb;
   logic [15:0]              crc_step;
   logic                     crc_done;
   logic                     swap;
   logic [TX_BITS_WIDTH-1:0] frame_asm;
   logic [NB_W-1:0]          frame_len;

   assign accept   = in_tvalid & in_tready;
   assign crc_fb   = crc[15] ^ cur_word[15];
   assign crc_step = {crc[14:0], 1'b0} ^ (crc_fb ? POLY : 16'h0000);
   assign crc_done = (state == S_CRC) && (bit_cnt == 4'd15);
   assign swap     = (state == S_FULL) && (!frame_valid || frame_done);

   // Frame built on the edge the CRC finishes, so it uses crc_step (the CRC
   // after the 16th bit) rather than the registered value. Payload bits above
   // the packet's words are zero because the first word clears the register.
   assign frame_asm = (TX_BITS_WIDTH'(PREAMBLE) << (16 * int'(word_cnt) + 16))
                    | (TX_BITS_WIDTH'(payload) << 16)
                    | TX_BITS_WIDTH'(crc_step);
   assign frame_len = NB_W'(PRE_WIDTH + 16 * int'(word_cnt) + 16);

   // ---------------------------------------------------------------- state reg
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // --------------------------------------------------------------- next state
   // NOTE: the default assignment at the top of a combinational block keeps
   // every path assigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_CRC;
         S_CRC: begin
            if (bit_cnt == 4'd15) begin
               if (last_q)                                  state_nxt = S_FULL;
               else if (int'(word_cnt) == MAX_WORDS)        state_nxt = S_DROP;
               else                                         state_nxt = S_IDLE;
            end
         end
         S_FULL: if (swap)               state_nxt = S_IDLE;
         S_DROP: if (accept && in_tlast) state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      in_tready = 1'b0;
      case (state)
         S_IDLE, S_DROP: in_tready = 1'b1;
         default:        in_tready = 1'b0;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   // NOTE: the staging and frame registers are small flop banks, not RAM, so
   // they are reset along with the control state; a reset therefore also
   // discards any partial packet and staged frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         payload      <= '0;
         cur_word     <= '0;
         crc          <= 16'hFFFF;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         last_q       <= 1'b0;
         stage_bits   <= '0;
         stage_nbits  <= '0;
         tx_bits      <= '0;
         tx_nbits     <= '0;
         frame_valid  <= 1'b0;
         err_overflow <= 1'b0;
         frames_sent  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cur_word <= in_tdata;
                  last_q   <= in_tlast;
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + CNT_W'(1);
                  if (word_cnt == '0) begin
                     crc     <= 16'hFFFF;
                     payload <= PAY_W'(in_tdata);
                  end else begin
                     payload <= {payload[PAY_W-17:0], in_tdata};
                  end
               end
            end
            S_CRC: begin
               crc      <= crc_step;
               cur_word <= {cur_word[14:0], 1'b0};
               bit_cnt  <= bit_cnt + 4'd1;
               if (crc_done) begin
                  if (last_q) begin
                     stage_bits  <= frame_asm;
                     stage_nbits <= frame_len;
                  end else if (int'(word_cnt) == MAX_WORDS) begin
                     err_overflow <= 1'b1;
                  end
               end
            end
            S_FULL: if (swap)               word_cnt <= '0;
            S_DROP: if (accept && in_tlast) word_cnt <= '0;
            default: ;
         endcase

         // Active buffer: swap wins over a plain frame_done clear.
         if (swap) begin
            tx_bits     <= stage_bits;
            tx_nbits    <= stage_nbits;
            frame_valid <= 1'b1;
         end else if (frame_done && frame_valid) begin
            tx_bits     <= '0;
            tx_nbits    <= '0;
            frame_valid <= 1'b0;
         end

         if (frame_done && frame_valid) frames_sent <= frames_sent + 16'd1;
      end
   end

endmodule

// File: tb/tb_tag_frame_builder.sv
module tb_tag_frame_builder;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [15:0]  in_tdata = '0;
   logic         in_tvalid = 1'b0;
   logic         in_tlast = 1'b0;
   logic         in_tready;
   logic         frame_done = 1'b0;
   logic [127:0] tx_bits;
   logic [7:0]   tx_nbits;
   logic         frame_valid;
   logic         err_overflow;
   logic [15:0]  frames_sent;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tag_frame_builder #(
      .TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(7), .MAX_WORDS(6),
      .PRE_WIDTH(16), .PREAMBLE(16'hAAAA)
   ) dut (
      .clk(clk), .reset(reset),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
      .in_tready(in_tready), .frame_done(frame_done),
      .tx_bits(tx_bits), .tx_nbits(tx_nbits), .frame_valid(frame_valid),
      .err_overflow(err_overflow), .frames_sent(frames_sent)
   );

   // Bit-serial CRC-16-CCITT reference (init 0xFFFF, MSB first, no final XOR).
   // Words sit in the low 16*n bits, first word highest.
   function automatic logic [15:0] crc_model(input logic [95:0] words, input int n);
      logic [15:0] c;
      logic [15:0] w;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         w = words[(n-1-i)*16 +: 16];
         for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ w[b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_tvalid = 1'b0; in_tlast = 1'b0; frame_done = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      @(posedge clk); #1;
      frame_done = 1'b0;
   endtask

   // Presents one word; returns #1 after its accept edge.
   task automatic send_word(input logic [15:0] d, input logic last);
      int n = 0;
      in_tdata = d; in_tlast = last; in_tvalid = 1'b1;
      while (!in_tready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_tready) begin
         $display("FAIL send_timeout word=%h in_tready=%b required=1", d, in_tready);
         miscompares++;
      end
      vectors++;
      @(posedge clk); #1;
      in_tvalid = 1'b0; in_tlast = 1'b0;
   endtask

   // Sends a word, checks in_tready is low for exactly 16 cycles, and returns
   // #1 after the CRC-completion edge k+16.
   task automatic send_and_wait(input logic [15:0] d, input logic last);
      send_word(d, last);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (in_tready !== 1'b0) begin
            $display("FAIL tready_busy word=%h cyc=%0d got=%b required=0", d, i, in_tready);
            miscompares++;
         end
         vectors++;
      end
      @(posedge clk); #1;
      if (in_tready !== !last) begin
         $display("FAIL tready_after_crc word=%h got=%b required=%b", d, in_tready, !last);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_reset();
      do_reset();
      if (tx_bits !== 128'h0)    begin $display("FAIL rst_tx_bits got=%h required=0", tx_bits); miscompares++; end
      vectors++;
      if (tx_nbits !== 8'd0)     begin $display("FAIL rst_tx_nbits got=%0d required=0", tx_nbits); miscompares++; end
      vectors++;
      if (frame_valid !== 1'b0)  begin $display("FAIL rst_frame_valid got=%b required=0", frame_valid); miscompares++; end
      vectors++;
      if (err_overflow !== 1'b0) begin $display("FAIL rst_err_overflow got=%b required=0", err_overflow); miscompares++; end
      vectors++;
      if (frames_sent !== 16'd0) begin $display("FAIL rst_frames_sent got=%0d required=0", frames_sent); miscompares++; end
      vectors++;
      if (in_tready !== 1'b1)    begin $display("FAIL rst_in_tready got=%b required=1", in_tready); miscompares++; end
      vectors++;
   endtask

   task automatic test_done_idle();
      pulse_done();
      pulse_done();
      if (frames_sent !== 16'd0) begin $display("FAIL idle_done_count got=%0d required=0", frames_sent); miscompares++; end
      vectors++;
      if (frame_valid !== 1'b0 || tx_bits !== 128'h0 || tx_nbits !== 8'd0) begin
         $display("FAIL idle_done_outputs valid=%b bits=%h nbits=%0d required 0/0/0", frame_valid, tx_bits, tx_nbits);
         miscompares++;
      end
      vectors++;
      if (in_tready !== 1'b1) begin $display("FAIL idle_done_tready got=%b required=1", in_tready); miscompares++; end
      vectors++;
   endtask

   task automatic test_single_word();
      do_reset();
      send_and_wait(16'h0000, 1'b1);
      if (frame_valid !== 1'b0) begin $display("FAIL single_early_valid got=%b required=0", frame_valid); miscompares++; end
      vectors++;
      @(posedge clk); #1;
      if (tx_bits !== 128'hAAAA_0000_1D0F) begin $display("FAIL single_tx_bits got=%h required=%h", tx_bits, 128'hAAAA_0000_1D0F); miscompares++; end
      vectors++;
      if (tx_nbits !== 8'd48) begin $display("FAIL single_tx_nbits got=%0d required=48", tx_nbits); miscompares++; end
      vectors++;
      if (frame_valid !== 1'b1) begin $display("FAIL single_frame_valid got=%b required=1", frame_valid); miscompares++; end
      vectors++;
      if (in_tready !== 1'b1) begin $display("FAIL single_tready got=%b required=1", in_tready); miscompares++; end
      vectors++;
   endtask

   task automatic test_six_words();
      logic [95:0]  words;
      logic [127:0] exp;
      words = 96'h0001_0002_0003_0004_0005_0006;
      exp   = {16'hAAAA, words, crc_model(words, 6)};
      do_reset();
      for (int i = 1; i <= 6; i++) send_and_wait(16'(i), (i == 6));
      @(posedge clk); #1;
      if (tx_nbits !== 8'd128) begin $display("FAIL six_tx_nbits got=%0d required=128", tx_nbits); miscompares++; end
      vectors++;
      if (tx_bits !== exp) begin $display("FAIL six_tx_bits got=%h required=%h", tx_bits, exp); miscompares++; end
      vectors++;
      if (frame_valid !== 1'b1) begin $display("FAIL six_frame_valid got=%b required=1", frame_valid); miscompares++; end
      vectors++;
   endtask

   task automatic test_overflow();
      logic [127:0] frame_a;
      logic [127:0] frame_c;
      frame_a = 128'hAAAA_0000_1D0F;
      frame_c = {80'h0, 16'hAAAA, 16'h1234, crc_model(96'h1234, 1)};
      do_reset();
      send_and_wait(16'h0000, 1'b1);
      @(posedge clk); #1;
      for (int i = 1; i <= 6; i++) begin
         send_and_wait(16'h0100 + 16'(i), 1'b0);
         if (err_overflow !== (i == 6)) begin
            $display("FAIL ovf_flag word=%0d got=%b required=%b", i, err_overflow, (i == 6));
            miscompares++;
         end
         vectors++;
      end
      send_word(16'h0107, 1'b1);
      if (in_tready !== 1'b1) begin $display("FAIL ovf_drop_exit_tready got=%b required=1", in_tready); miscompares++; end
      vectors++;
      if (tx_bits !== frame_a || frame_valid !== 1'b1) begin
         $display("FAIL ovf_tx_unchanged got=%h valid=%b required=%h valid=1", tx_bits, frame_valid, frame_a);
         miscompares++;
      end
      vectors++;
      send_and_wait(16'h1234, 1'b1);
      @(posedge clk); #1;
      if (tx_bits !== frame_a) begin $display("FAIL ovf_wait_full got=%h required=%h", tx_bits, frame_a); miscompares++; end
      vectors++;
      pulse_done();
      if (tx_bits !== frame_c) begin $display("FAIL ovf_next_bits got=%h required=%h", tx_bits, frame_c); miscompares++; end
      vectors++;
      if (tx_nbits !== 8'd48) begin $display("FAIL ovf_next_nbits got=%0d required=48", tx_nbits); miscompares++; end
      vectors++;
      if (err_overflow !== 1'b1) begin $display("FAIL ovf_sticky got=%b required=1", err_overflow); miscompares++; end
      vectors++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] frame_a;
      logic [127:0] frame_b;
      frame_a = {80'h0, 16'hAAAA, 16'h0001, crc_model(96'h0001, 1)};
      frame_b = {64'h0, 16'hAAAA, 16'h0002, 16'h0003, crc_model(96'h0002_0003, 2)};
      do_reset();
      send_and_wait(16'h0001, 1'b1);
      @(posedge clk); #1;
      if (tx_bits !== frame_a) begin $display("FAIL dbuf_a got=%h required=%h", tx_bits, frame_a); miscompares++; end
      vectors++;
      send_and_wait(16'h0002, 1'b0);
      send_and_wait(16'h0003, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      if (in_tready !== 1'b0) begin $display("FAIL dbuf_full_tready got=%b required=0", in_tready); miscompares++; end
      vectors++;
      if (tx_bits !== frame_a) begin $display("FAIL dbuf_a_held got=%h required=%h", tx_bits, frame_a); miscompares++; end
      vectors++;
      pulse_done();
      if (tx_bits !== frame_b) begin $display("FAIL dbuf_b got=%h required=%h", tx_bits, frame_b); miscompares++; end
      vectors++;
      if (tx_nbits !== 8'd64) begin $display("FAIL dbuf_b_nbits got=%0d required=64", tx_nbits); miscompares++; end
      vectors++;
      if (frames_sent !== 16'd1) begin $display("FAIL dbuf_count1 got=%0d required=1", frames_sent); miscompares++; end
      vectors++;
      if (in_tready !== 1'b1) begin $display("FAIL dbuf_idle_tready got=%b required=1", in_tready); miscompares++; end
      vectors++;
      pulse_done();
      if (tx_bits !== 128'h0 || tx_nbits !== 8'd0 || frame_valid !== 1'b0) begin
         $display("FAIL dbuf_clear bits=%h nbits=%0d valid=%b required 0/0/0", tx_bits, tx_nbits, frame_valid);
         miscompares++;
      end
      vectors++;
      if (frames_sent !== 16'd2) begin $display("FAIL dbuf_count2 got=%0d required=2", frames_sent); miscompares++; end
      vectors++;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      send_and_wait(16'h0011, 1'b0);
      send_and_wait(16'h0022, 1'b0);
      send_word(16'h0033, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      if (in_tready !== 1'b1 || frame_valid !== 1'b0 || tx_bits !== 128'h0 ||
          tx_nbits !== 8'd0 || err_overflow !== 1'b0 || frames_sent !== 16'd0) begin
         $display("FAIL midrst_outputs tready=%b valid=%b bits=%h nbits=%0d ovf=%b sent=%0d required 1/0/0/0/0/0",
                  in_tready, frame_valid, tx_bits, tx_nbits, err_overflow, frames_sent);
         miscompares++;
      end
      vectors++;
      send_and_wait(16'h0000, 1'b1);
      @(posedge clk); #1;
      if (tx_bits !== 128'hAAAA_0000_1D0F) begin $display("FAIL midrst_frame got=%h required=%h", tx_bits, 128'hAAAA_0000_1D0F); miscompares++; end
      vectors++;
      if (tx_nbits !== 8'd48) begin $display("FAIL midrst_nbits got=%0d required=48", tx_nbits); miscompares++; end
      vectors++;
   endtask

   initial begin
      test_reset();
      test_done_idle();
      test_single_word();
      test_six_words();
      test_overflow();
      test_back_to_back();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule
